// File: rtl/hard_bit_collector.sv
// hard_bit_collector
//   Front end of the hard-decision BCH decoder. It takes one codeword as a
//   serial stream of signed LLR samples under a valid/ready handshake and
//   slices each sample to a hard bit. The bits are assembled into hard_bits,
//   with the first sample at the highest-degree position. The block then
//   pulses syn_start for one cycle and holds the vector stable until the
//   syndrome calculator returns syn_done.
//
//   Optional feature macro: HBC_MINLLR_EN
//     When defined, the block tracks the two least-reliable bit positions of
//     each frame and drives them on min1_pos / min2_pos.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   frame_start  opens a frame (sampled only in IDLE); n is the codeword length
//   in_valid / in_ready / in_llr / in_last   sample stream
//   syn_start / syn_done                     handshake to the syndrome calculator
//   hard_bits, cw_n                          assembled codeword and its length
//   busy                                     high outside IDLE
//   err_len, err_cfg                         one-cycle error pulses
//   min1_pos, min2_pos                       least-reliable positions (HBC_MINLLR_EN)
module hard_bit_collector #(
  parameter int unsigned N_MAX = 1023,
  parameter int unsigned LLR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [9:0]       n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LLR_W-1:0] in_llr,
  input  logic             in_last,
  output logic             syn_start,
  input  logic             syn_done,
  output logic [N_MAX-1:0] hard_bits,
  output logic [9:0]       cw_n,
  output logic             busy,
  output logic             err_len,
`ifdef HBC_MINLLR_EN
  output logic [9:0]       min1_pos,
  output logic [9:0]       min2_pos,
`endif
  output logic             err_cfg
);

  typedef enum logic [1:0] {StIdle, StCollect, StFire, StWait} state_e;

  state_e             state_q, state_d;
  logic [N_MAX-1:0]   hard_bits_q, hard_bits_d;
  logic [9:0]         cw_n_q, cw_n_d;
  logic [9:0]         cnt_q, cnt_d;
  logic               err_len_q, err_len_d;
  logic               err_cfg_q, err_cfg_d;

  logic               n_ok;
  logic               frame_open;
  logic               accept;
  logic               last_k;
  logic [9:0]         idx;

  assign n_ok       = (n != 10'd0) && (32'(n) <= N_MAX);
  assign frame_open = (state_q == StIdle) && frame_start && n_ok;
  assign accept     = (state_q == StCollect) && in_valid;
  assign last_k     = (cnt_q == cw_n_q - 10'd1);
  // First sample lands on the highest-degree coefficient.
  assign idx        = cw_n_q - 10'd1 - cnt_q;

  always_comb begin
    state_d     = state_q;
    hard_bits_d = hard_bits_q;
    cw_n_d      = cw_n_q;
    cnt_d       = cnt_q;
    err_len_d   = 1'b0;
    err_cfg_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (frame_start) begin
          if (n_ok) begin
            cw_n_d      = n;
            hard_bits_d = '0;
            cnt_d       = '0;
            state_d     = StCollect;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      StCollect: begin
        if (in_valid) begin
          // Sign bit is the hard decision; an LLR of 0 slices to 0.
          hard_bits_d[idx] = in_llr[LLR_W-1];
          cnt_d            = cnt_q + 10'd1;
          if (last_k || in_last) begin
            state_d   = StFire;
            // Either the last position arrived without in_last, or in_last came early.
            err_len_d = last_k ^ in_last;
          end
        end
      end
      StFire: state_d = StWait;
      StWait: begin
        if (syn_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hard_bits_q <= '0;
      cw_n_q      <= '0;
      cnt_q       <= '0;
      err_len_q   <= 1'b0;
      err_cfg_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hard_bits_q <= hard_bits_d;
      cw_n_q      <= cw_n_d;
      cnt_q       <= cnt_d;
      err_len_q   <= err_len_d;
      err_cfg_q   <= err_cfg_d;
    end
  end

  // Moore-decoded handshake outputs: no input-to-output combinational path.
  assign in_ready  = (state_q == StCollect);
  assign syn_start = (state_q == StFire);
  assign busy      = (state_q != StIdle);
  assign hard_bits = hard_bits_q;
  assign cw_n      = cw_n_q;
  assign err_len   = err_len_q;
  assign err_cfg   = err_cfg_q;

`ifdef HBC_MINLLR_EN
  localparam int unsigned MagW = LLR_W - 1;

  logic [LLR_W-1:0] neg_llr;
  logic [MagW-1:0]  mag;
  logic [MagW-1:0]  min1_mag_q, min1_mag_d, min2_mag_q, min2_mag_d;
  logic [9:0]       min1_pos_q, min1_pos_d, min2_pos_q, min2_pos_d;

  assign neg_llr = -in_llr;

  // |llr|, with the most-negative code saturating to the largest magnitude.
  always_comb begin
    mag = in_llr[MagW-1:0];
    if (in_llr[LLR_W-1]) begin
      if (in_llr[MagW-1:0] == '0) mag = '1;
      else                        mag = neg_llr[MagW-1:0];
    end
  end

  // Strict less-than keeps the earlier sample on ties.
  always_comb begin
    min1_mag_d = min1_mag_q;
    min2_mag_d = min2_mag_q;
    min1_pos_d = min1_pos_q;
    min2_pos_d = min2_pos_q;
    if (frame_open) begin
      min1_mag_d = '1;
      min2_mag_d = '1;
      min1_pos_d = '0;
      min2_pos_d = '0;
    end else if (accept) begin
      if (mag < min1_mag_q) begin
        min2_mag_d = min1_mag_q;
        min2_pos_d = min1_pos_q;
        min1_mag_d = mag;
        min1_pos_d = idx;
      end else if (mag < min2_mag_q) begin
        min2_mag_d = mag;
        min2_pos_d = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min1_mag_q <= '1;
      min2_mag_q <= '1;
      min1_pos_q <= '0;
      min2_pos_q <= '0;
    end else begin
      min1_mag_q <= min1_mag_d;
      min2_mag_q <= min2_mag_d;
      min1_pos_q <= min1_pos_d;
      min2_pos_q <= min2_pos_d;
    end
  end

  assign min1_pos = min1_pos_q;
  assign min2_pos = min2_pos_q;
`endif

endmodule
